commit_ctrl: RTL
================

Name:
commit_ctrl

Overview:
- In-order commit sequencer between the reorder buffer head and the register file.
- Each cycle it inspects the ROB head entry. It retires the entry when the entry is ready.
- It drives the register file write port (index/value/reorder) and pops the ROB.
- It runs the store-commit handshake with the load/store buffer.
- It raises the misbranch flush and redirect PC on a mispredicted branch, and latches halt.

Parameters:
- DATA_W, 32, data width.
- REG_TAG_W, 5, architectural register index width; index 0 means no write.
- ROB_TAG_W, 4, ROB tag width; tag 0 means no tag.
- ADDR_W, 32, PC width.
- FLUSH_HOLD, 1, idle cycles after the misbranch pulse before commit resumes (0..15).

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- rdy in 1: global ready; when low the block freezes.
- in_rob_head_valid in 1: ROB non-empty.
- in_rob_head_ready in 1: head result available.
- in_rob_head_tag in ROB_TAG_W: head tag.
- in_rob_head_rd in REG_TAG_W: destination register.
- in_rob_head_value in DATA_W: result value.
- in_rob_head_type in 2: 0=REG, 1=BRANCH, 2=STORE, 3=HALT.
- in_rob_head_mispredict in 1: branch mispredicted.
- in_rob_head_target in ADDR_W: correct PC.
- in_lsb_store_done in 1: LSB finished the committed store.
- out_rob_pop out 1: combinational; ROB advances its head at this edge.
- out_reg_index out REG_TAG_W: register-file write index (registered).
- out_reg_value out DATA_W: register-file write value (registered).
- out_reg_reorder out ROB_TAG_W: tag of the committing entry (registered).
- out_misbranch out 1: one-cycle flush pulse (registered).
- out_fetch_pc out ADDR_W: redirect PC, valid with out_misbranch.
- out_lsb_store_commit out 1: one-cycle store-commit pulse.
- out_lsb_store_tag out ROB_TAG_W: tag of the store being committed.
- out_halt out 1: sticky halt.
- out_commit_count out 32: retired-instruction counter.

Behaviour:
- Reset:
  - State goes to RUN.
  - All registered outputs go to 0, including halt and count.
  - out_rob_pop is 0 during reset.
  - Reset mid-operation (in WAIT_STORE or FLUSH) abandons that operation; no pop is issued.
- "Eligible" means rdy & in_rob_head_valid & in_rob_head_ready, in state RUN.
- Register port defaults:
  - Every cycle without a commit write, the registered port is index 0, value 0, reorder 0.
  - out_misbranch and out_lsb_store_commit default to 0.
- RUN, eligible entry, by type:
  - REG:
    - out_rob_pop=1 this cycle.
    - Next cycle the port shows {rd, value, tag}.
    - Count increments.
    - rd=0 commits normally; the port shows index 0.
  - BRANCH, no mispredict: handled the same as REG.
  - BRANCH, mispredict:
    - Pop and port write as for REG.
    - The port write appears in cycle t+1.
    - out_misbranch=1 and out_fetch_pc=target in cycle t+2 only, so the rd write is never dropped by the flush.
    - State goes to FLUSH.
  - STORE:
    - No pop.
    - out_lsb_store_commit=1 and out_lsb_store_tag=tag for exactly one cycle (t+1).
    - State goes to WAIT_STORE.
  - HALT:
    - out_rob_pop=1.
    - out_halt=1 from t+1 onward, until reset.
    - Count increments.
    - State goes to HALTED.
- RUN with the head not valid or not ready: wait; no pop.
- WAIT_STORE:
  - When rdy & in_lsb_store_done: out_rob_pop=1 (combinational), count increments, state returns to RUN.
  - The earliest next commit is the following cycle.
  - in_lsb_store_done is ignored in any other state.
- FLUSH:
  - No pops and no port writes.
  - After the misbranch cycle, wait FLUSH_HOLD further cycles, then return to RUN.
  - ROB inputs are ignored throughout.
- HALTED: terminal; no pops, no writes, no pulses.
- rdy low:
  - State, counters and all registered outputs hold.
  - out_rob_pop is forced to 0.
  - Pulses extend by the stall (consumers are also rdy-gated).
  - FLUSH_HOLD counting pauses.
- out_commit_count is 32-bit and wraps 0xFFFFFFFF -> 0.
- Throughput is at most one commit per cycle in RUN. No commit occurs in the cycle a store completes.

Test Plan:
- REG commit: head {type0, rd=5, value=0x1234, tag=3, ready} -> pop=1 that cycle; next cycle port = (5, 0x1234, 3); count=1.
- Back-to-back commits: 3 ready REG entries (tags 1,2,3) -> pop=1 for 3 consecutive cycles; port shows tags 1,2,3 in successive cycles; count=3.
- Mispredict: BRANCH {rd=1, value=0x104, target=0x200, mispredict} at t -> t+1 port (1, 0x104, tag); t+2 misbranch=1 with fetch_pc=0x200; with FLUSH_HOLD=1, no pop at t+3 even if the head is ready; commit resumes at t+4.
- Store handshake: STORE tag=6 -> store_commit pulse with tag 6, no pop; done asserted 4 cycles later -> pop=1 that cycle; count +1; port index stays 0.
- rdy stall: drop rdy mid-WAIT_STORE with done=1 -> no pop and count unchanged; raise rdy -> pop in the first cycle where rdy & done.
- HALT and reset: HALT commit -> out_halt=1 and later ready heads are ignored; assert rst -> halt=0, count=0, state RUN.

Source files
------------

// File: rtl/commit_ctrl.sv
// In-order commit sequencer: retires the ROB head into the register file, runs the
// store-commit handshake with the LSB, raises misbranch flushes and latches halt.
module commit_ctrl #(
   parameter int DATA_W     = 32,
   parameter int REG_TAG_W  = 5,
   parameter int ROB_TAG_W  = 4,
   parameter int ADDR_W     = 32,
   parameter int FLUSH_HOLD = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 in_rob_head_valid,
   input  logic                 in_rob_head_ready,
   input  logic [ROB_TAG_W-1:0] in_rob_head_tag,
   input  logic [REG_TAG_W-1:0] in_rob_head_rd,
   input  logic [DATA_W-1:0]    in_rob_head_value,
   input  logic [1:0]           in_rob_head_type,
   input  logic                 in_rob_head_mispredict,
   input  logic [ADDR_W-1:0]    in_rob_head_target,
   input  logic                 in_lsb_store_done,
   output logic                 out_rob_pop,
   output logic [REG_TAG_W-1:0] out_reg_index,
   output logic [DATA_W-1:0]    out_reg_value,
   output logic [ROB_TAG_W-1:0] out_reg_reorder,
   output logic                 out_misbranch,
   output logic [ADDR_W-1:0]    out_fetch_pc,
   output logic                 out_lsb_store_commit,
   output logic [ROB_TAG_W-1:0] out_lsb_store_tag,
   output logic                 out_halt,
   output logic [31:0]          out_commit_count
);

   // state      | meaning
   // S_RUN      | inspect ROB head, retire when ready
   // S_WAIT_ST  | store handed to LSB, waiting for store_done to pop
   // S_FLUSH    | misbranch pending/flush hold; ROB ignored
   // S_HALTED   | terminal until reset
   typedef enum logic [1:0] {S_RUN, S_WAIT_ST, S_FLUSH, S_HALTED} state_t;

   localparam logic [1:0] T_REG    = 2'd0;
   localparam logic [1:0] T_BRANCH = 2'd1;
   localparam logic [1:0] T_STORE  = 2'd2;
   localparam logic [1:0] T_HALT   = 2'd3;

   // Hold counter starts one above FLUSH_HOLD so the first FLUSH cycle
   // leaves room for the rd write before the misbranch pulse.
   localparam logic [4:0] HOLD_TOP = 5'(FLUSH_HOLD + 1);

   state_t              state_q, state_d;
   logic [4:0]          hold_q, hold_d;
   logic [ADDR_W-1:0]   target_q, target_d;
   logic                pop, wr_en, mb_set, sc_set, halt_set, cnt_inc;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      target_d = target_q;
      pop      = 1'b0;
      wr_en    = 1'b0;
      mb_set   = 1'b0;
      sc_set   = 1'b0;
      halt_set = 1'b0;
      cnt_inc  = 1'b0;
      if (rdy) begin
         case (state_q)
            S_RUN: begin
               if (in_rob_head_valid && in_rob_head_ready) begin
                  case (in_rob_head_type)
                     T_REG: begin
                        pop     = 1'b1;
                        wr_en   = 1'b1;
                        cnt_inc = 1'b1;
                     end
                     T_BRANCH: begin
                        pop     = 1'b1;
                        wr_en   = 1'b1;
                        cnt_inc = 1'b1;
                        if (in_rob_head_mispredict) begin
                           state_d  = S_FLUSH;
                           hold_d   = HOLD_TOP;
                           target_d = in_rob_head_target;
                        end
                     end
                     T_STORE: begin
                        sc_set  = 1'b1;
                        state_d = S_WAIT_ST;
                     end
                     default: begin
                        pop      = 1'b1;
                        cnt_inc  = 1'b1;
                        halt_set = 1'b1;
                        state_d  = S_HALTED;
                     end
                  endcase
               end
            end
            S_WAIT_ST: begin
               if (in_lsb_store_done) begin
                  pop     = 1'b1;
                  cnt_inc = 1'b1;
                  state_d = S_RUN;
               end
            end
            S_FLUSH: begin
               mb_set = (hold_q == HOLD_TOP);
               if (hold_q == 5'd0) state_d = S_RUN;
               else                hold_d  = hold_q - 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign out_rob_pop = pop & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q              <= S_RUN;
         hold_q               <= '0;
         target_q             <= '0;
         out_reg_index        <= '0;
         out_reg_value        <= '0;
         out_reg_reorder      <= '0;
         out_misbranch        <= 1'b0;
         out_fetch_pc         <= '0;
         out_lsb_store_commit <= 1'b0;
         out_lsb_store_tag    <= '0;
         out_halt             <= 1'b0;
         out_commit_count     <= '0;
      end else if (rdy) begin
         state_q              <= state_d;
         hold_q               <= hold_d;
         target_q             <= target_d;
         out_reg_index        <= wr_en ? in_rob_head_rd    : '0;
         out_reg_value        <= wr_en ? in_rob_head_value : '0;
         out_reg_reorder      <= wr_en ? in_rob_head_tag   : '0;
         out_misbranch        <= mb_set;
         out_fetch_pc         <= mb_set ? target_q : '0;
         out_lsb_store_commit <= sc_set;
         if (sc_set)   out_lsb_store_tag <= in_rob_head_tag;
         if (halt_set) out_halt          <= 1'b1;
         if (cnt_inc)  out_commit_count  <= out_commit_count + 32'd1;
      end
   end

endmodule
